acog_seq: RTL and testbench

Instruction sequencer for one ACog. It sits directly upstream of the cog memory and generates the per-cog state code, the fetch address (PC) and the latched S/D addresses. It evaluates each instruction's condition field against the C/Z flags and gates D write-back and flag updates. It also holds the instruction in READ while the execute unit reports a wait (WAITCNT, hub access).

---
 rtl/acog_seq_if.sv | 48 ++++
 rtl/acog_seq.sv | 136 +++++++++++++
 tb/tb_acog_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/acog_seq_if.sv
// Sequencer <-> cog memory / execute unit signal bundle.
// ACOG_SEQ_SINGLE_STEP_EN adds the step_in / halted_o debug pair.
interface acog_seq_if #(
  parameter int unsigned MEM_WIDTH = 9
);
  logic [31:0]          f_data_in;
  logic                 exec_wait_in;
  logic                 jump_in;
  logic [MEM_WIDTH-1:0] jump_addr_in;
  logic                 z_result_in;
  logic                 c_result_in;
  logic [1:0]           state_o;
  logic [MEM_WIDTH-1:0] f_addr_o;
  logic [MEM_WIDTH-1:0] s_addr_o;
  logic [MEM_WIDTH-1:0] d_addr_o;
  logic [5:0]           opcode_o;
  logic                 imm_o;
  logic                 cond_true_o;
  logic                 d_write_o;
  logic                 z_flag_o;
  logic                 c_flag_o;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
  logic                 step_in;
  logic                 halted_o;
`endif

  // Environment side: memory, execute unit, debugger.
  modport master (
`ifdef ACOG_SEQ_SINGLE_STEP_EN
    output step_in,
    input  halted_o,
`endif
    output f_data_in, exec_wait_in, jump_in, jump_addr_in, z_result_in, c_result_in,
    input  state_o, f_addr_o, s_addr_o, d_addr_o, opcode_o, imm_o,
    input  cond_true_o, d_write_o, z_flag_o, c_flag_o
  );

  // Sequencer side.
  modport slave (
`ifdef ACOG_SEQ_SINGLE_STEP_EN
    input  step_in,
    output halted_o,
`endif
    input  f_data_in, exec_wait_in, jump_in, jump_addr_in, z_result_in, c_result_in,
    output state_o, f_addr_o, s_addr_o, d_addr_o, opcode_o, imm_o,
    output cond_true_o, d_write_o, z_flag_o, c_flag_o
  );
endinterface

// File: rtl/acog_seq.sv
// ACog instruction sequencer: FETCH/DECODE/READ/WBACK, condition evaluation, C/Z flags, PC.
// Optional single-step debug mode under ACOG_SEQ_SINGLE_STEP_EN.
module acog_seq #(
  parameter int unsigned               MEM_WIDTH = 9,
  parameter logic [MEM_WIDTH-1:0]      RESET_PC  = 9'h1F4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  acog_seq_if.slave  bus
);

  localparam int unsigned FIELD_W = 9;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_READ   = 2'd2,
    ST_WBACK  = 2'd3
  } state_t;

  typedef struct packed {
    logic [5:0]         opcode;
    logic               wz;
    logic               wc;
    logic               wr;
    logic               imm;
    logic [3:0]         cond;
    logic [FIELD_W-1:0] d;
    logic [FIELD_W-1:0] s;
  } instr_t;

  state_t               state_q, state_d;
  logic [MEM_WIDTH-1:0] pc_q, pc_d;
  instr_t               ir_q, ir_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;
  logic                 cond_true_q, cond_true_d;
  logic                 d_write_q, d_write_d;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
  logic                 halted_q, halted_d;
`endif

  // Next-state, PC, flag and strobe logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    c_d       = c_q;
    d_write_d = 1'b0;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
    halted_d  = halted_q;
`endif

    case (state_q)
      ST_FETCH: begin
`ifdef ACOG_SEQ_SINGLE_STEP_EN
        if (!halted_q || bus.step_in) begin
          state_d  = ST_DECODE;
          halted_d = 1'b0;
        end
`else
        state_d = ST_DECODE;
`endif
      end
      ST_DECODE: begin
        ir_d    = instr_t'(bus.f_data_in);
        state_d = ST_READ;
      end
      ST_READ: begin
        // A pending wait only stalls an instruction that will actually execute.
        if (!(cond_true_q && bus.exec_wait_in)) begin
          state_d   = ST_WBACK;
          d_write_d = ir_q.wr & cond_true_q;
        end
      end
      ST_WBACK: begin
        if (cond_true_q) begin
          if (ir_q.wz) z_d = bus.z_result_in;
          if (ir_q.wc) c_d = bus.c_result_in;
        end
        if (cond_true_q && bus.jump_in) pc_d = bus.jump_addr_in;
        else                            pc_d = pc_q + MEM_WIDTH'(1);
        state_d = ST_FETCH;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
        halted_d = 1'b1;
`endif
      end
      default: state_d = ST_FETCH;
    endcase

    // Registered copy of cond[{C,Z}] tracking the next IR and flags.
    cond_true_d = ir_d.cond[{c_d, z_d}];
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      cond_true_q <= 1'b0;
      d_write_q   <= 1'b0;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
      halted_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      c_q         <= c_d;
      cond_true_q <= cond_true_d;
      d_write_q   <= d_write_d;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
      halted_q    <= halted_d;
`endif
    end
  end

  assign bus.state_o     = state_q;
  assign bus.f_addr_o    = pc_q;
  assign bus.s_addr_o    = MEM_WIDTH'(ir_q.s);
  assign bus.d_addr_o    = MEM_WIDTH'(ir_q.d);
  assign bus.opcode_o    = ir_q.opcode;
  assign bus.imm_o       = ir_q.imm;
  assign bus.cond_true_o = cond_true_q;
  assign bus.d_write_o   = d_write_q;
  assign bus.z_flag_o    = z_q;
  assign bus.c_flag_o    = c_q;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
  assign bus.halted_o    = halted_q;
`endif

endmodule

// File: tb/tb_acog_seq.sv
// Self-checking bench for acog_seq: directed scenarios plus randomized instructions vs. a reference model.
module tb_acog_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // Reference architectural state.
  logic [8:0] m_pc;
  logic       m_z;
  logic       m_c;

  acog_seq_if #(.MEM_WIDTH(9)) bus ();

  acog_seq #(.MEM_WIDTH(9), .RESET_PC(9'h1F4)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic wz, input logic wc,
                                     input logic wr, input logic im, input logic [3:0] cond,
                                     input logic [8:0] d, input logic [8:0] s);
    return {op, wz, wc, wr, im, cond, d, s};
  endfunction

  // Condition rule: bit {C,Z} of the 4-bit cond field selects execution.
  function automatic logic cond_ok(input logic [31:0] ins, input logic z, input logic c);
    logic [3:0] cf;
    int idx;
    cf  = ins[21:18];
    idx = (c ? 2 : 0) + (z ? 1 : 0);
    return cf[idx];
  endfunction

  // Entered at a negedge while the DUT is in FETCH; returns at the next FETCH negedge.
  task automatic exec_instr(input logic [31:0] ins, input int nwait, input logic jmp,
                            input logic [8:0] ja, input logic zr, input logic cr);
    logic ct;
    int   w;
    ct = cond_ok(ins, m_z, m_c);
    w  = ct ? nwait : 0;

    n_checks++;
    if (bus.state_o !== 2'd0 || bus.f_addr_o !== m_pc || bus.d_write_o !== 1'b0)
      $display("FAIL fetch: state=%0d addr=%h dw=%b, want state=0 addr=%h dw=0",
               bus.state_o, bus.f_addr_o, bus.d_write_o, m_pc);
    else n_pass++;
    n_checks++;
    if (bus.z_flag_o !== m_z || bus.c_flag_o !== m_c)
      $display("FAIL flags: z=%b c=%b, want z=%b c=%b", bus.z_flag_o, bus.c_flag_o, m_z, m_c);
    else n_pass++;
    bus.f_data_in = ins;

    @(negedge clk);
    n_checks++;
    if (bus.state_o !== 2'd1 || bus.d_write_o !== 1'b0)
      $display("FAIL decode: state=%0d dw=%b, want state=1 dw=0", bus.state_o, bus.d_write_o);
    else n_pass++;

    @(negedge clk);
    n_checks++;
    if (bus.state_o !== 2'd2 || bus.opcode_o !== ins[31:26] || bus.imm_o !== ins[22] ||
        bus.d_addr_o !== ins[17:9] || bus.s_addr_o !== ins[8:0] || bus.cond_true_o !== ct ||
        bus.d_write_o !== 1'b0)
      $display("FAIL read: state=%0d op=%h i=%b d=%h s=%h ct=%b dw=%b, want 2 %h %b %h %h %b 0",
               bus.state_o, bus.opcode_o, bus.imm_o, bus.d_addr_o, bus.s_addr_o,
               bus.cond_true_o, bus.d_write_o, ins[31:26], ins[22], ins[17:9], ins[8:0], ct);
    else n_pass++;
    bus.exec_wait_in = (nwait > 0);
    bus.jump_in      = jmp;
    bus.jump_addr_in = ~ja;

    for (int j = 1; j <= w; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.state_o !== 2'd2 || bus.d_write_o !== 1'b0)
        $display("FAIL wait_hold: cycle=%0d state=%0d dw=%b, want state=2 dw=0",
                 j, bus.state_o, bus.d_write_o);
      else n_pass++;
      bus.exec_wait_in = (j < nwait);
    end

    @(negedge clk);
    n_checks++;
    if (bus.state_o !== 2'd3 || bus.d_write_o !== (ins[23] & ct))
      $display("FAIL wback: state=%0d dw=%b, want state=3 dw=%b",
               bus.state_o, bus.d_write_o, ins[23] & ct);
    else n_pass++;
    bus.exec_wait_in = 1'b0;
    bus.jump_in      = jmp;
    bus.jump_addr_in = ja;
    bus.z_result_in  = zr;
    bus.c_result_in  = cr;

    if (ct && ins[25]) m_z = zr;
    if (ct && ins[24]) m_c = cr;
    m_pc = (ct && jmp) ? ja : 9'((m_pc + 9'd1) % 512);

    @(negedge clk);
    bus.jump_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.state_o !== 2'd0 || bus.f_addr_o !== 9'h1F4 || bus.d_write_o !== 1'b0 ||
        bus.s_addr_o !== 9'h0 || bus.d_addr_o !== 9'h0 || bus.opcode_o !== 6'h0 ||
        bus.imm_o !== 1'b0 || bus.z_flag_o !== 1'b0 || bus.c_flag_o !== 1'b0)
      $display("FAIL reset: state=%0d pc=%h dw=%b s=%h d=%h op=%h i=%b z=%b c=%b",
               bus.state_o, bus.f_addr_o, bus.d_write_o, bus.s_addr_o, bus.d_addr_o,
               bus.opcode_o, bus.imm_o, bus.z_flag_o, bus.c_flag_o);
    else n_pass++;
    m_pc = 9'h1F4; m_z = 1'b0; m_c = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exec_instr(mk(6'h28, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 9'h012, 9'h034), 0, 1'b0, 9'h0, 1'b1, 1'b1);
    n_checks++;
    if (bus.f_addr_o !== 9'h1F5)
      $display("FAIL basic_pc: addr=%h, want 1f5", bus.f_addr_o);
    else n_pass++;
  endtask

  task automatic test_cond_false();
    exec_instr(mk(6'h28, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 9'h0AA, 9'h155), 0, 1'b1, 9'h010, 1'b1, 1'b1);
  endtask

  task automatic test_wait();
    exec_instr(mk(6'h3E, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 9'h003, 9'h004), 5, 1'b0, 9'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flags();
    exec_instr(mk(6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h001, 9'h002), 0, 1'b0, 9'h0, 1'b1, 1'b0);
    exec_instr(mk(6'h28, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 9'h005, 9'h006), 0, 1'b0, 9'h0, 1'b0, 1'b1);
  endtask

  task automatic test_pc_wrap();
    exec_instr(mk(6'h17, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 9'h0, 9'h1FF), 0, 1'b1, 9'h1FF, 1'b0, 1'b0);
    exec_instr(mk(6'h28, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 9'h0, 9'h0), 0, 1'b0, 9'h0, 1'b0, 1'b0);
    n_checks++;
    if (bus.f_addr_o !== 9'h000) $display("FAIL pc_wrap: addr=%h, want 000", bus.f_addr_o);
    else n_pass++;
    exec_instr(mk(6'h17, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 9'h0, 9'h1FB), 0, 1'b1, 9'h1FB, 1'b0, 1'b0);
    exec_instr(mk(6'h17, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 9'h0, 9'h000), 2, 1'b1, 9'h000, 1'b0, 1'b0);
    n_checks++;
    if (bus.f_addr_o !== 9'h000) $display("FAIL jump_zero: addr=%h, want 000", bus.f_addr_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    // Set both flags so the async clear is observable.
    exec_instr(mk(6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h0, 9'h0), 0, 1'b0, 9'h0, 1'b1, 1'b1);
    bus.f_data_in = mk(6'h3E, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h077, 9'h066);
    @(negedge clk);
    @(negedge clk);
    bus.exec_wait_in = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.state_o !== 2'd0 || bus.f_addr_o !== 9'h1F4 || bus.d_write_o !== 1'b0 ||
        bus.z_flag_o !== 1'b0 || bus.c_flag_o !== 1'b0 || bus.s_addr_o !== 9'h0)
      $display("FAIL async_reset: state=%0d pc=%h dw=%b z=%b c=%b s=%h, want 0 1f4 0 0 0 000",
               bus.state_o, bus.f_addr_o, bus.d_write_o, bus.z_flag_o, bus.c_flag_o, bus.s_addr_o);
    else n_pass++;
    @(negedge clk);
    bus.exec_wait_in = 1'b0;
    rst_n = 1'b1;
    m_pc = 9'h1F4; m_z = 1'b0; m_c = 1'b0;
    exec_instr(mk(6'h28, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 9'h0, 9'h0), 0, 1'b0, 9'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      exec_instr($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.f_data_in    = '0;
    bus.exec_wait_in = 1'b0;
    bus.jump_in      = 1'b0;
    bus.jump_addr_in = '0;
    bus.z_result_in  = 1'b0;
    bus.c_result_in  = 1'b0;
`ifdef ACOG_SEQ_SINGLE_STEP_EN
    bus.step_in      = 1'b1;
`endif
    m_pc = 9'h1F4; m_z = 1'b0; m_c = 1'b0;

    test_reset();
    test_basic();
    test_cond_false();
    test_wait();
    test_flags();
    test_pc_wrap();
    test_reset_mid_wait();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
